// File: rtl/ysyx_25060166_lsu_rmw.sv
// ysyx_25060166_lsu_rmw: byte/half/word load-store bridge onto a strobe-less word bus using read-modify-write
module ysyx_25060166_lsu_rmw (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [2:0] {IDLE, RD, RWAIT, WR, WWAIT, RESP} state_t;
  state_t state, state_nx;
  logic        wen;
  logic [1:0]  size;
  logic [31:0] addr, wdata, wbuf;
  logic [4:0]  sh;
  logic [31:0] lane_mask, ext, merged;
  // half accesses force-align by dropping addr[0]; word accesses use no shift
  always_comb begin
    sh = size[1] ? 5'd0 : (size[0] ? {addr[1], 4'b0} : {addr[1:0], 3'b0});
    lane_mask = size[1] ? 32'hFFFF_FFFF : ((size[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh);
    ext = (mem_rdata & lane_mask) >> sh;
    merged = (mem_rdata & ~lane_mask) | ((wdata << sh) & lane_mask);
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = (req_wen && req_size[1]) ? WR : RD;
      RD:      if (mem_req_ready) state_nx = RWAIT;
      RWAIT:   if (mem_rsp_valid) state_nx = wen ? WR : RESP;
      WR:      if (mem_req_ready) state_nx = WWAIT;
      WWAIT:   if (mem_rsp_valid) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wen        <= 1'b0;
      size       <= 2'b0;
      addr       <= 32'h0;
      wdata      <= 32'h0;
      wbuf       <= 32'h0;
      resp_rdata <= 32'h0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        wen   <= req_wen;
        size  <= req_size;
        addr  <= req_addr;
        wdata <= req_wdata;
        wbuf  <= req_wdata;
      end
      if (state == RWAIT && mem_rsp_valid) begin
        if (wen) wbuf <= merged;
        else resp_rdata <= ext;
      end
    end
  end
  assign req_ready     = state == IDLE;
  assign resp_valid    = state == RESP;
  assign mem_req_valid = state == RD || state == WR;
  assign mem_we        = state == WR;
  assign mem_addr      = mem_req_valid ? {addr[31:2], 2'b00} : 32'h0;
  assign mem_wdata     = mem_we ? wbuf : 32'h0;
endmodule

// File: tb/tb_ysyx_25060166_lsu_rmw.sv
// tb_ysyx_25060166_lsu_rmw: directed vectors; expected bus reads/writes and responses go to a scoreboard checked by a monitor
module tb_ysyx_25060166_lsu_rmw;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_wen = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready, resp_valid, mem_req_valid, mem_we, mem_req_ready, mem_rsp_valid;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 0, mem_word = 0;
  logic ready_en = 1, rsp_pend = 0, rsp_noise = 0;
  int total = 0, bad = 0, cyc = 0, acc_cyc = 0;
  typedef struct {int kind; logic [31:0] addr; logic [31:0] data; int lat;} ev_t;
  typedef struct {logic we; logic [1:0] sz; logic [31:0] addr, wd, mem, wval, rd; int lat;} vec_t;
  ev_t sb[$];
  vec_t vt[9];
  assign mem_req_ready = ready_en;
  assign mem_rsp_valid = rsp_pend | rsp_noise;
  ysyx_25060166_lsu_rmw dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] a, input logic [31:0] d, input int lat);
    ev_t e;
    e.kind = kind; e.addr = a; e.data = d; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic check_ev(input int kind, input logic [31:0] a, input logic [31:0] d, input int lat);
    ev_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h, want none", kind, a, d);
      return;
    end
    e = sb.pop_front();
    if (e.kind != kind || e.addr !== a || e.data !== d || (kind == 2 && e.lat != lat)) begin
      bad++;
      $display("FAIL event: got kind=%0d addr=%h data=%h lat=%0d want kind=%0d addr=%h data=%h lat=%0d",
               kind, a, d, lat, e.kind, e.addr, e.data, e.lat);
    end
  endtask

  // zero-wait word memory: response one cycle after the handshake, junk data otherwise
  initial begin
    logic hs, hw;
    logic [31:0] hd;
    forever begin
      @(negedge clk);
      hs = mem_req_valid && mem_req_ready;
      hw = mem_we;
      hd = mem_wdata;
      @(posedge clk);
      #1;
      if (hs && hw) mem_word = hd;
      rsp_pend = hs;
      mem_rdata = hs ? mem_word : ~mem_word;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (req_valid && req_ready) acc_cyc = cyc;
        if (mem_req_valid && mem_req_ready) check_ev(mem_we ? 1 : 0, mem_addr, mem_we ? mem_wdata : 32'h0, 0);
        if (resp_valid) check_ev(2, 32'h0, resp_rdata, cyc - acc_cyc);
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1; req_wen = we; req_size = sz; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 0; req_wen = ~we; req_size = $urandom; req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = resp_valid;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_timeout: got no resp_valid, want resp_valid within 40 cycles", name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    mem_word = v.mem;
    if (!v.we || !v.sz[1]) push(0, {v.addr[31:2], 2'b00}, 32'h0, 0);
    if (v.we) push(1, {v.addr[31:2], 2'b00}, v.wval, 0);
    push(2, 32'h0, v.rd, v.lat);
    issue(v.we, v.sz, v.addr, v.wd);
    wait_done("vec");
  endtask

  initial begin
    vt[0] = '{1'b0, 2'd2, 32'h8000_0007, 32'h0,         32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF, 3};
    vt[1] = '{1'b0, 2'd0, 32'h8000_0002, 32'h0,         32'h1122_3344, 32'h0,         32'h0000_0022, 3};
    vt[2] = '{1'b1, 2'd1, 32'h8000_0003, 32'hFFFF_ABCD, 32'h1122_3344, 32'hABCD_3344, 32'h0000_0022, 5};
    vt[3] = '{1'b1, 2'd0, 32'h8000_0101, 32'h0000_005A, 32'hAABB_CCDD, 32'hAABB_5ADD, 32'h0000_0022, 5};
    vt[4] = '{1'b1, 2'd2, 32'h1000_0006, 32'h1234_5678, 32'h0,         32'h1234_5678, 32'h0000_0022, 3};
    vt[5] = '{1'b0, 2'd1, 32'h1000_0001, 32'h0,         32'h1234_5678, 32'h0,         32'h0000_5678, 3};
    vt[6] = '{1'b0, 2'd0, 32'h1000_0003, 32'h0,         32'h1234_5678, 32'h0,         32'h0000_0012, 3};
    vt[7] = '{1'b0, 2'd3, 32'h1000_0002, 32'h0,         32'h1234_5678, 32'h0,         32'h1234_5678, 3};
    vt[8] = '{1'b1, 2'd0, 32'h2000_000B, 32'hFFFF_FF80, 32'h0,         32'h8000_0000, 32'h1234_5678, 5};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_mem_req_valid", {31'h0, mem_req_valid}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    rst_n = 1;
    for (int i = 0; i < 9; i++) run_vec(vt[i]);
    // backpressure: bus stalls 4 cycles in RD while the request side and response line toggle
    mem_word = 32'hCAFE_F00D;
    ready_en = 0;
    push(0, 32'h3000_0000, 32'h0, 0);
    push(2, 32'h0, 32'h0000_CAFE, 7);
    issue(1'b0, 2'd1, 32'h3000_0002, 32'h0);
    for (int k = 0; k < 4; k++) begin
      req_valid = (k % 2) == 1;
      req_wen = (k % 2) == 0;
      req_addr = $urandom;
      rsp_noise = (k % 2) == 0;
      @(negedge clk);
      chk("bp_mem_addr", mem_addr, 32'h3000_0000);
      chk("bp_mem_we", {31'h0, mem_we}, 32'h0);
      chk("bp_mem_req_valid", {31'h0, mem_req_valid}, 32'h1);
      chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
      @(posedge clk);
      #1;
    end
    rsp_noise = 0;
    req_valid = 0;
    ready_en = 1;
    wait_done("bp");
    // reset while waiting for the read half of a byte store
    mem_word = 32'hAABB_CCDD;
    push(0, 32'h5000_0004, 32'h0, 0);
    issue(1'b1, 2'd0, 32'h5000_0005, 32'h0000_0077);
    @(posedge clk);
    #1;
    chk("rwait_mem_req_valid", {31'h0, mem_req_valid}, 32'h0);
    #2;
    rst_n = 0;
    #1;
    chk("abort_mem_req_valid", {31'h0, mem_req_valid}, 32'h0);
    chk("abort_mem_we", {31'h0, mem_we}, 32'h0);
    chk("abort_req_ready", {31'h0, req_ready}, 32'h1);
    chk("abort_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("abort_resp_rdata", resp_rdata, 32'h0);
    chk("abort_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
    rsp_noise = 1;
    @(posedge clk);
    #1;
    rsp_noise = 0;
    repeat (6) @(negedge clk);
    chk("post_abort_req_ready", {31'h0, req_ready}, 32'h1);
    chk("post_abort_resp_rdata", resp_rdata, 32'h0);
    @(posedge clk);
    #1;
    mem_word = 32'h0BAD_F00D;
    push(0, 32'h4000_0000, 32'h0, 0);
    push(2, 32'h0, 32'h0BAD_F00D, 3);
    issue(1'b0, 2'd2, 32'h4000_0000, 32'h0);
    wait_done("post_reset_load");
    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ysyx_25060166_lsu_rmw.md
YSYX_25060166_LSU_RMW -- requirements
Module: ysyx_25060166_lsu_rmw

Interface
REQ-001 SHALL have a single clock and an asynchronous active-low reset, as fixed below.
REQ-002 SHALL have these ports, listed as name, direction, width, meaning:
- clk, in, 1: clock; all state updates on the rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- req_valid, in, 1: core access request.
- req_ready, out, 1: block can accept a request.
- req_wen, in, 1: 1 = store, 0 = load.
- req_size, in, 2: access size; 00 = byte, 01 = half, 10 or 11 = word.
- req_addr, in, 32: byte address.
- req_wdata, in, 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid, out, 1: one-cycle pulse marking access completion.
- resp_rdata, out, 32: load data, right-aligned and zero-extended.
- mem_req_valid, out, 1: word-bus request.
- mem_req_ready, in, 1: word bus accepts the request.
- mem_we, out, 1: word-bus write enable.
- mem_addr, out, 32: word-aligned bus address.
- mem_wdata, out, 32: full-word write data.
- mem_rsp_valid, in, 1: bus read data or write acknowledge.
- mem_rdata, in, 32: bus read data.

Function
REQ-003 The block SHALL bridge byte/half/word accesses onto a word-only bus with no byte strobes, using read-modify-write for sub-word stores.
REQ-004 The FSM states SHALL be IDLE, RD, RWAIT, WR, WWAIT, RESP.
REQ-005 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted when req_valid and req_ready are both 1.
REQ-006 On acceptance, req_wen, req_size, req_addr and req_wdata SHALL be registered. Later changes on the req_* inputs SHALL be ignored until the block returns to IDLE.
REQ-007 Transitions out of IDLE on acceptance:
- to WR for a word store;
- to RD for any load or sub-word store.
REQ-008 In RD, mem_req_valid SHALL be 1 and mem_we SHALL be 0; on mem_req_ready the FSM SHALL go to RWAIT.
REQ-009 In RWAIT, on mem_rsp_valid:
- a load SHALL capture the extracted data into resp_rdata and go to RESP;
- a sub-word store SHALL register the merged word and go to WR.
REQ-010 In WR, mem_req_valid SHALL be 1, mem_we SHALL be 1 and mem_wdata SHALL hold the write word; on mem_req_ready the FSM SHALL go to WWAIT.
REQ-011 In WWAIT, on mem_rsp_valid the FSM SHALL go to RESP.
REQ-012 RESP SHALL assert resp_valid for exactly one cycle and then return to IDLE unconditionally.
REQ-013 mem_addr SHALL equal {addr[31:2], 2'b00} whenever mem_req_valid is 1, and 0 otherwise.
REQ-014 mem_req_valid, once asserted, SHALL stay asserted with stable mem_addr, mem_we and mem_wdata until mem_req_ready is seen.
REQ-015 Lane selection:
- byte lane = addr[1:0], shift = 8 × lane;
- half lane = addr[1], with addr[0] ignored (force-aligned);
- word accesses ignore addr[1:0].
REQ-016 Load extraction SHALL be: byte → {24'h0, selected byte}; half → {16'h0, selected half}; word → mem_rdata unmodified.
REQ-017 Store merge SHALL replace only the selected byte or half lane of mem_rdata with req_wdata[7:0] or req_wdata[15:0]; all other lanes SHALL be preserved bit-exactly.
REQ-018 With zero-wait-state memory (ready in the issuing cycle, response the next cycle), resp_valid SHALL rise 3 cycles after acceptance for loads and word stores, and 5 cycles after acceptance for sub-word stores.
REQ-019 mem_rsp_valid outside RWAIT or WWAIT, and mem_req_ready outside RD or WR, SHALL be ignored with no state change.
REQ-020 resp_rdata SHALL hold its value until the next load completes; stores SHALL NOT modify it.
REQ-021 There SHALL be no timeout: the block SHALL wait indefinitely in RD, RWAIT, WR or WWAIT.

Reset
REQ-022 On rst_n low, independent of clk, the block SHALL:
- set the state to IDLE;
- set req_ready = 1;
- set resp_valid, mem_req_valid and mem_we to 0;
- set mem_addr, mem_wdata and resp_rdata to 0;
- clear all registered request fields.
REQ-023 Reset asserted mid-access SHALL abort the access with no resp_valid pulse and no further bus request; a bus response arriving after reset is released SHALL be ignored per REQ-019.
REQ-024 The first request SHALL be acceptable in the first rising edge after rst_n deasserts.

Verification
REQ-025 A bench SHALL cover these directed scenarios:
- Word load: addr 0x80000007, mem_rdata 0xDEADBEEF, zero-wait memory → mem_addr 0x80000004, resp_valid at cycle 3, resp_rdata 0xDEADBEEF.
- Byte load: addr 0x80000002, mem_rdata 0x11223344 → resp_rdata 0x00000022.
- Half store: addr 0x80000003, wdata 0xFFFFABCD, memory word 0x11223344 → one read, then a write of 0xABCD3344 to 0x80000000, resp_valid at cycle 5.
- Byte store: lane 1, wdata 0x5A, memory word 0xAABBCCDD → write 0xAABB5ADD.
- Backpressure: mem_req_ready held 0 for 4 cycles in RD while req_* and mem_rsp_valid toggle → mem_addr and mem_we stable, no state change, correct result after ready.
- Reset in RWAIT of a sub-word store → mem_req_valid 0 immediately, no write issued, no resp_valid pulse, req_ready 1.
